// File: rtl/rs_alu_station_pkg.sv
// Shared types and constants for the integer-ALU reservation station
// and the oldest-ready select logic it shares with the other stations.
package rs_alu_station_pkg;

  localparam int RS_DEPTH = 8;
  localparam int TAG_W    = 8;
  localparam int DATA_W   = 32;

  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef enum logic [3:0] {
    ALUOP_ADD  = 4'd0,
    ALUOP_SUB  = 4'd1,
    ALUOP_AND  = 4'd2,
    ALUOP_OR   = 4'd3,
    ALUOP_XOR  = 4'd4,
    ALUOP_SLL  = 4'd5,
    ALUOP_SRL  = 4'd6,
    ALUOP_SRA  = 4'd7,
    ALUOP_SLT  = 4'd8,
    ALUOP_SLTU = 4'd9,
    ALUOP_LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [3:0]        aluop;
    logic              alusrc1;
    logic              alusrc2;
    logic [TAG_W-1:0]  rd_phy;
    logic [TAG_W-1:0]  src1_tag;
    logic [TAG_W-1:0]  src2_tag;
    logic              src1_rdy;
    logic              src2_rdy;
    logic [DATA_W-1:0] src1_val;
    logic [DATA_W-1:0] src2_val;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] inst_num;
  } rs_entry_t;

  // The null tag names "no producer" and must never wake anything.
  function automatic logic tag_hit(input logic             bcast_valid,
                                   input logic [TAG_W-1:0] bcast_tag,
                                   input logic [TAG_W-1:0] src_tag);
    return bcast_valid && (src_tag != NULL_TAG) && (src_tag == bcast_tag);
  endfunction

endpackage

// File: rtl/rs_alu_station_if.sv
// Dispatch, CDB, flush and issue signals of the ALU reservation station.
// master = upstream pipeline / ALU side, slave = the station.
interface rs_alu_station_if #(
  parameter int DEPTH = rs_alu_station_pkg::RS_DEPTH
);
  import rs_alu_station_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              add_rs_on;
  logic [DATA_W-1:0] add_alu_pc;
  logic [3:0]        out_add_ALUOP;
  logic              out_add_ALUSrc1;
  logic              out_add_ALUSrc2;
  logic [TAG_W-1:0]  add_rd_phy_reg;
  logic [TAG_W-1:0]  out_add_Operand1_phy;
  logic [TAG_W-1:0]  out_add_Operand2_phy;
  logic [1:0]        out_add_valid;
  logic [DATA_W-1:0] op1_data;
  logic [DATA_W-1:0] op2_data;
  logic [DATA_W-1:0] out_add_immediate;
  logic [DATA_W-1:0] out_add_inst_num;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              flush;
  logic [DATA_W-1:0] flush_inst_num;
  logic              alu_ready;

  logic              rs_full;
  logic [CNT_W-1:0]  rs_count;
  logic              issue_valid;
  logic [DATA_W-1:0] issue_pc;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [DATA_W-1:0] issue_imm;
  logic [DATA_W-1:0] issue_inst_num;
  logic [3:0]        issue_aluop;
  logic              issue_alusrc1;
  logic              issue_alusrc2;
  logic [TAG_W-1:0]  issue_rd_phy;

  modport master (
    output add_rs_on, add_alu_pc, out_add_ALUOP, out_add_ALUSrc1, out_add_ALUSrc2,
           add_rd_phy_reg, out_add_Operand1_phy, out_add_Operand2_phy, out_add_valid,
           op1_data, op2_data, out_add_immediate, out_add_inst_num,
           cdb_valid, cdb_tag, cdb_data, flush, flush_inst_num, alu_ready,
    input  rs_full, rs_count, issue_valid, issue_pc, issue_op1, issue_op2, issue_imm,
           issue_inst_num, issue_aluop, issue_alusrc1, issue_alusrc2, issue_rd_phy
  );

  modport slave (
    input  add_rs_on, add_alu_pc, out_add_ALUOP, out_add_ALUSrc1, out_add_ALUSrc2,
           add_rd_phy_reg, out_add_Operand1_phy, out_add_Operand2_phy, out_add_valid,
           op1_data, op2_data, out_add_immediate, out_add_inst_num,
           cdb_valid, cdb_tag, cdb_data, flush, flush_inst_num, alu_ready,
    output rs_full, rs_count, issue_valid, issue_pc, issue_op1, issue_op2, issue_imm,
           issue_inst_num, issue_aluop, issue_alusrc1, issue_alusrc2, issue_rd_phy
  );

endinterface

// File: rtl/rs_oldest_select.sv
// Oldest-ready picker: grants the requesting slot with the smallest key.
// Equal keys fall back to the lower index so the grant is always one-hot.
module rs_oldest_select #(
  parameter int N     = 8,
  parameter int KEY_W = 32
) (
  input  logic [N-1:0]            req,
  input  logic [N-1:0][KEY_W-1:0] key,
  output logic [N-1:0]            grant,
  output logic                    found
);

  assign found = |req;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [N-1:0] beaten;
      for (gj = 0; gj < N; gj++) begin : g_vs
        if (gj == gi) begin : g_self
          assign beaten[gj] = 1'b0;
        end else if (gj < gi) begin : g_lower
          assign beaten[gj] = req[gj] && (key[gj] <= key[gi]);
        end else begin : g_upper
          assign beaten[gj] = req[gj] && (key[gj] < key[gi]);
        end
      end
      assign grant[gi] = req[gi] && !(|beaten);
    end
  endgenerate

endmodule

// File: rtl/rs_alu_station.sv
// Integer-ALU reservation station: CDB-snooping entry array, oldest-ready
// select, registered issue stage and branch-mispredict flush.
module rs_alu_station
  import rs_alu_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  rs_alu_station_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  rs_entry_t        entry_reg  [DEPTH];
  rs_entry_t        entry_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  rs_entry_t        issue_reg;
  logic             issue_valid_reg;

  logic [DEPTH-1:0]             hit1_vec, hit2_vec, kill_vec, ready_vec;
  logic [DEPTH-1:0]             alloc_vec, grant_vec;
  logic [DEPTH-1:0][DATA_W-1:0] inst_vec;
  logic                         found, rs_full, accept, issue_load;
  logic                         bypass1, bypass2;
  rs_entry_t                    new_entry, winner;

  assign rs_full = (count_reg == CNT_W'(DEPTH));

  // A dispatch younger than the flush point belongs to the squashed path.
  assign accept = bus.add_rs_on && !rs_full &&
                  (!bus.flush || (bus.out_add_inst_num <= bus.flush_inst_num));

  // Lowest free slot from the registered valid bits; slots freed this edge wait a cycle.
  assign alloc_vec  = ~valid_reg & (valid_reg + DEPTH'(1));
  assign issue_load = !bus.flush && (!issue_valid_reg || bus.alu_ready) && found;

  assign bypass1 = tag_hit(bus.cdb_valid, bus.cdb_tag, bus.out_add_Operand1_phy);
  assign bypass2 = tag_hit(bus.cdb_valid, bus.cdb_tag, bus.out_add_Operand2_phy);

  always_comb begin
    new_entry          = '0;
    new_entry.pc       = bus.add_alu_pc;
    new_entry.aluop    = bus.out_add_ALUOP;
    new_entry.alusrc1  = bus.out_add_ALUSrc1;
    new_entry.alusrc2  = bus.out_add_ALUSrc2;
    new_entry.rd_phy   = bus.add_rd_phy_reg;
    new_entry.src1_tag = bus.out_add_Operand1_phy;
    new_entry.src2_tag = bus.out_add_Operand2_phy;
    new_entry.imm      = bus.out_add_immediate;
    new_entry.inst_num = bus.out_add_inst_num;
    new_entry.src1_rdy = bus.out_add_valid[1] || bypass1;
    new_entry.src2_rdy = bus.out_add_valid[0] || bypass2;
    if (bus.out_add_valid[1]) begin
      new_entry.src1_val = bus.op1_data;
    end else if (bypass1) begin
      new_entry.src1_val = bus.cdb_data;
    end
    if (bus.out_add_valid[0]) begin
      new_entry.src2_val = bus.op2_data;
    end else if (bypass2) begin
      new_entry.src2_val = bus.cdb_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign hit1_vec[gi]  = !entry_reg[gi].src1_rdy &&
                             tag_hit(bus.cdb_valid, bus.cdb_tag, entry_reg[gi].src1_tag);
      assign hit2_vec[gi]  = !entry_reg[gi].src2_rdy &&
                             tag_hit(bus.cdb_valid, bus.cdb_tag, entry_reg[gi].src2_tag);
      assign kill_vec[gi]  = bus.flush && valid_reg[gi] &&
                             (entry_reg[gi].inst_num > bus.flush_inst_num);
      // Registered ready bits keep entries woken this cycle out of select.
      assign ready_vec[gi] = valid_reg[gi] && entry_reg[gi].src1_rdy && entry_reg[gi].src2_rdy;
      assign inst_vec[gi]  = entry_reg[gi].inst_num;
      assign valid_next[gi] = (accept && alloc_vec[gi]) ||
                              (valid_reg[gi] && !kill_vec[gi] && !(issue_load && grant_vec[gi]));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i] = entry_reg[i];
      if (accept && alloc_vec[i]) begin
        entry_next[i] = new_entry;
      end else begin
        if (hit1_vec[i]) begin
          entry_next[i].src1_rdy = 1'b1;
          entry_next[i].src1_val = bus.cdb_data;
        end
        if (hit2_vec[i]) begin
          entry_next[i].src2_rdy = 1'b1;
          entry_next[i].src2_val = bus.cdb_data;
        end
      end
    end
  end

  rs_oldest_select #(
    .N     (DEPTH),
    .KEY_W (DATA_W)
  ) u_select (
    .req   (ready_vec),
    .key   (inst_vec),
    .grant (grant_vec),
    .found (found)
  );

  always_comb begin
    winner     = '0;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_vec[i]) begin
        winner = entry_reg[i];
      end
      count_next = count_next + CNT_W'(valid_next[i]);
    end
  end

  // Payload needs no reset: valid_reg gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_reg[i] <= entry_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg       <= '0;
      count_reg       <= '0;
      issue_valid_reg <= 1'b0;
      issue_reg       <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      if (bus.flush) begin
        if (issue_valid_reg &&
            ((issue_reg.inst_num > bus.flush_inst_num) || bus.alu_ready)) begin
          issue_valid_reg <= 1'b0;
        end
      end else if (!issue_valid_reg || bus.alu_ready) begin
        issue_valid_reg <= found;
        if (found) begin
          issue_reg <= winner;
        end
      end
    end
  end

  assign bus.rs_full        = rs_full;
  assign bus.rs_count       = count_reg;
  assign bus.issue_valid    = issue_valid_reg;
  assign bus.issue_pc       = issue_reg.pc;
  assign bus.issue_op1      = issue_reg.src1_val;
  assign bus.issue_op2      = issue_reg.src2_val;
  assign bus.issue_imm      = issue_reg.imm;
  assign bus.issue_inst_num = issue_reg.inst_num;
  assign bus.issue_aluop    = issue_reg.aluop;
  assign bus.issue_alusrc1  = issue_reg.alusrc1;
  assign bus.issue_alusrc2  = issue_reg.alusrc2;
  assign bus.issue_rd_phy   = issue_reg.rd_phy;

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: directed scenarios then random traffic, every
// cycle compared against a queue-based model of the station.
module tb_rs_alu_station;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] inst;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  op;
    logic        s1;
    logic        s2;
    logic [7:0]  rd;
    logic [7:0]  t1;
    logic [7:0]  t2;
    logic        r1;
    logic        r2;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   pass_count  = 0;

  op_t  m_q[$];
  op_t  m_iss;
  bit   m_iv = 1'b0;

  rs_alu_station_if #(.DEPTH(DEPTH)) bus ();

  rs_alu_station #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: the station is an unordered bag of ops; issue picks the oldest ready one.
  task automatic model_step();
    bit   was_full;
    int   best;
    op_t  n;
    if (reset) begin
      m_q.delete();
      m_iv = 1'b0;
      return;
    end
    was_full = (m_q.size() >= DEPTH);
    if (bus.flush) begin
      for (int i = m_q.size() - 1; i >= 0; i--)
        if (m_q[i].inst > bus.flush_inst_num) m_q.delete(i);
      if (m_iv && (m_iss.inst > bus.flush_inst_num || bus.alu_ready)) m_iv = 1'b0;
    end else if (!m_iv || bus.alu_ready) begin
      best = -1;
      for (int i = 0; i < m_q.size(); i++)
        if (m_q[i].r1 && m_q[i].r2 && (best < 0 || m_q[i].inst < m_q[best].inst)) best = i;
      if (best >= 0) begin
        m_iss = m_q[best];
        m_iv  = 1'b1;
        m_q.delete(best);
      end else begin
        m_iv = 1'b0;
      end
    end
    for (int i = 0; i < m_q.size(); i++) begin
      if (bus.cdb_valid && bus.cdb_tag != 0) begin
        if (!m_q[i].r1 && m_q[i].t1 == bus.cdb_tag) begin m_q[i].r1 = 1'b1; m_q[i].v1 = bus.cdb_data; end
        if (!m_q[i].r2 && m_q[i].t2 == bus.cdb_tag) begin m_q[i].r2 = 1'b1; m_q[i].v2 = bus.cdb_data; end
      end
    end
    if (bus.add_rs_on && !was_full && (!bus.flush || bus.out_add_inst_num <= bus.flush_inst_num)) begin
      n.pc = bus.add_alu_pc;       n.imm = bus.out_add_immediate; n.inst = bus.out_add_inst_num;
      n.op = bus.out_add_ALUOP;    n.s1 = bus.out_add_ALUSrc1;    n.s2 = bus.out_add_ALUSrc2;
      n.rd = bus.add_rd_phy_reg;   n.t1 = bus.out_add_Operand1_phy; n.t2 = bus.out_add_Operand2_phy;
      n.r1 = bus.out_add_valid[1]; n.v1 = bus.op1_data;
      n.r2 = bus.out_add_valid[0]; n.v2 = bus.op2_data;
      if (!n.r1 && bus.cdb_valid && n.t1 != 0 && n.t1 == bus.cdb_tag) begin n.r1 = 1'b1; n.v1 = bus.cdb_data; end
      if (!n.r2 && bus.cdb_valid && n.t2 != 0 && n.t2 == bus.cdb_tag) begin n.r2 = 1'b1; n.v2 = bus.cdb_data; end
      m_q.push_back(n);
    end
  endtask

  task automatic idle();
    reset          = 1'b0;
    bus.add_rs_on  = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;
    bus.flush      = 1'b0;
    bus.flush_inst_num = '0;
    bus.alu_ready  = 1'b1;
  endtask

  task automatic disp(input logic [31:0] inst, input logic [1:0] vld, input logic [7:0] t1,
                      input logic [7:0] t2, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [7:0] rd);
    bus.add_rs_on            = 1'b1;
    bus.add_alu_pc           = $urandom;
    bus.out_add_ALUOP        = 4'($urandom_range(0, 10));
    bus.out_add_ALUSrc1      = 1'($urandom);
    bus.out_add_ALUSrc2      = 1'($urandom);
    bus.add_rd_phy_reg       = rd;
    bus.out_add_Operand1_phy = t1;
    bus.out_add_Operand2_phy = t2;
    bus.out_add_valid        = vld;
    bus.op1_data             = d1;
    bus.op2_data             = d2;
    bus.out_add_immediate    = $urandom;
    bus.out_add_inst_num     = inst;
  endtask

  task automatic cdb(input logic [7:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  // One clock: advance the model, let the DUT take the edge, compare, return inputs to idle.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rs_count", bus.rs_count, m_q.size());
    check("rs_full", bus.rs_full, m_q.size() == DEPTH);
    check("issue_valid", bus.issue_valid, m_iv);
    if (m_iv) begin
      check("issue_inst_num", bus.issue_inst_num, m_iss.inst);
      check("issue_op1", bus.issue_op1, m_iss.v1);
      check("issue_op2", bus.issue_op2, m_iss.v2);
      check("issue_misc", {bus.issue_pc, bus.issue_imm, bus.issue_aluop, bus.issue_alusrc1,
                           bus.issue_alusrc2, bus.issue_rd_phy},
            {m_iss.pc, m_iss.imm, m_iss.op, m_iss.s1, m_iss.s2, m_iss.rd});
    end
    idle();
  endtask

  logic [31:0] next_inst;

  initial begin
    idle();
    disp(0, 2'b00, 0, 0, 0, 0, 0);
    bus.add_rs_on = 1'b0;
    reset = 1'b1;
    model_step();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Ready-at-dispatch ADD issues after the next edge.
    disp(1, 2'b11, 8'h01, 8'h02, 32'd5, 32'd7, 8'h12);
    tick();
    tick();
    check("t1_op1", bus.issue_op1, 32'd5);
    check("t1_op2", bus.issue_op2, 32'd7);
    check("t1_rd", bus.issue_rd_phy, 8'h12);
    check("t1_count", bus.rs_count, 0);

    // Op2 waits on tag 0x21, woken by the CDB three cycles later.
    disp(2, 2'b10, 8'h05, 8'h21, 32'd9, 32'd0, 8'h13);
    tick(); tick(); tick(); tick();
    cdb(8'h21, 32'hDEAD);
    tick();
    check("t2_wait", bus.issue_valid, 1'b0);
    tick();
    check("t2_op2", bus.issue_op2, 32'hDEAD);

    // Fill all slots, overflow dispatch, then wake inst 20 and 40 together.
    for (int i = 0; i < DEPTH; i++) begin
      disp((i == DEPTH - 1) ? 32'd40 : 32'(20 + i), 2'b10, 8'h06,
           (i == 0 || i == DEPTH - 1) ? 8'h30 : 8'h31, 32'(i), 32'd0, 8'(i + 1));
      tick();
    end
    check("t3_full", bus.rs_full, 1'b1);
    disp(41, 2'b11, 8'h01, 8'h01, 1, 2, 8'h50);
    tick();
    check("t3_ignored", bus.rs_count, 8);
    cdb(8'h30, 32'h1234);
    tick();
    tick();
    check("t3_first", bus.issue_inst_num, 32'd20);
    tick();
    check("t3_second", bus.issue_inst_num, 32'd40);

    // Backpressure: wake the rest while the ALU stalls, then drain.
    cdb(8'h31, 32'h5555);
    bus.alu_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin bus.alu_ready = 1'b0; tick(); end
    for (int i = 0; i < 8; i++) tick();

    // Flush kills inst 12 and the issued 13; a same-cycle inst 14 is dropped.
    reset = 1'b1;
    tick();
    for (int i = 10; i <= 12; i++) begin disp(32'(i), 2'b10, 8'h07, 8'h40, 32'(i), 0, 8'(i)); tick(); end
    disp(13, 2'b11, 8'h07, 8'h07, 32'h13, 32'h31, 8'h0d);
    tick();
    bus.alu_ready = 1'b0;
    tick();
    check("t5_issued", bus.issue_inst_num, 32'd13);
    disp(14, 2'b11, 8'h01, 8'h01, 1, 1, 8'h0e);
    bus.flush = 1'b1; bus.flush_inst_num = 32'd11; bus.alu_ready = 1'b0;
    tick();
    check("t5_count", bus.rs_count, 2);
    check("t5_issue_killed", bus.issue_valid, 1'b0);

    // Reset with five entries and a pending issue, then dispatch again.
    for (int i = 15; i <= 17; i++) begin disp(32'(i), 2'b01, 8'h41, 8'h02, 0, 32'(i), 8'(i)); tick(); end
    disp(18, 2'b11, 8'h01, 8'h01, 32'h18, 32'h81, 8'h12);
    tick();
    bus.alu_ready = 1'b0;
    tick();
    check("t6_pending", bus.issue_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_count", bus.rs_count, 0);
    check("t6_issue", bus.issue_valid, 1'b0);
    disp(19, 2'b11, 8'h01, 8'h01, 32'h19, 32'h91, 8'h19);
    tick();
    tick();
    check("t6_after", bus.issue_inst_num, 32'd19);

    // Random traffic.
    next_inst = 100;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) != 0)
        disp(next_inst, 2'($urandom), 8'($urandom_range(1, 15)), 8'($urandom_range(1, 15)),
             $urandom, $urandom, 8'($urandom));
      next_inst = next_inst + 1;
      if ($urandom_range(0, 1) == 1) cdb(8'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 39) == 0) begin
        bus.flush = 1'b1;
        bus.flush_inst_num = next_inst - 32'($urandom_range(1, 8));
      end
      bus.alu_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
